mastermind_auto_guesser: RTL
============================

Name: mastermind_auto_guesser

Overview:
Automatic codebreaker that drives the game core's guess interface from the player side and consumes its Znarly/Zood feedback. It enumerates candidate patterns with an odometer and prunes shapes proven absent by 0/0 feedback. It issues each guess with a one-cycle grade strobe and waits for the feedback load strobe. It ends solved, failed or timed out, and is used for self-play demos and regression of the game core.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT for fb_valid before declaring timeout
GAP_CYCLES, 4, idle cycles between a feedback and the next candidate search (>=1)

Ports:
CLOCK_50  input  1  system clock
reset  input  1  asynchronous, active-high
start  input  1  level; sampled in IDLE or any DONE state, begins a new solve
abort  input  1  synchronous return to IDLE from any state
znarly  input  4  exact-match count from game core, valid with fb_valid
zood  input  4  shape-only match count, valid with fb_valid
fb_valid  input  1  one-cycle feedback load strobe from game core
game_over  input  1  level; game core has exhausted its rounds
guess  output  12  current guess, four 3-bit shapes, [2:0]=slot0 ... [11:9]=slot3
grade_it  output  1  one-cycle pulse requesting grading of guess
busy  output  1  high in SEARCH/ISSUE/WAIT/GAP
solved  output  1  high in DONE_OK
failed  output  1  high in DONE_FAIL
timeout_err  output  1  high in DONE_TO
guess_count  output  8  guesses issued this solve, saturates at 255

Behaviour:
- Reset (async): state IDLE; guess=12'h249 (1,1,1,1); candidate=12'h249; absent mask=6'b0; grade_it=0, busy=0, solved=0, failed=0, timeout_err=0, guess_count=0, timers 0.
- Shape encoding: legal shapes 1..6; 0 and 7 are never emitted.
- Odometer increment: slot0 is least significant; a digit goes 6->1 with carry. 6666 is the last candidate; there is no wrap past it.
- Absent mask: bit k-1 set means shape k is absent. A candidate is admissible if none of its four digits is absent.
- IDLE: on start, clear mask, candidate=1111, guess_count=0, next state SEARCH.
- DONE_OK / DONE_FAIL / DONE_TO: hold all outputs. start behaves as in IDLE.
- SEARCH: one admissibility check per cycle.
  - Admissible: go to ISSUE.
  - Not admissible and candidate≠6666: increment the candidate and stay in SEARCH.
  - Not admissible and candidate==6666: go to DONE_FAIL.
  - If all 6 shapes are absent, DONE_FAIL is reached within 1296 cycles.
- ISSUE (1 cycle): guess<=candidate, registered. grade_it=1 for exactly this cycle. guess_count++ (saturating). WAIT timer cleared. Next state WAIT. guess is stable from this edge until the next ISSUE.
- WAIT: the timer increments each cycle. The first matching rule below wins:
  1. fb_valid && znarly==4 -> DONE_OK.
  2. fb_valid otherwise:
     - if znarly+zood==0 (5-bit sum), OR into the mask the bits of all four guess digits;
     - then, if game_over or candidate==6666, go to DONE_FAIL;
     - else increment the candidate and go to GAP.
  3. game_over (no fb_valid) -> DONE_FAIL.
  4. Timer==TIMEOUT_CYCLES-1 -> DONE_TO.
- GAP: count GAP_CYCLES cycles, then SEARCH. game_over in GAP -> DONE_FAIL.
- Ignored inputs:
  - fb_valid is ignored outside WAIT.
  - start is ignored while busy.
- abort priority: abort overrides every transition. It returns to IDLE, drops busy and grade_it, and holds guess and guess_count at their last values.
- Reset during any state takes effect immediately, and grade_it drops asynchronously.
- Feedback latency from the game core is arbitrary, from 1 to TIMEOUT_CYCLES-1 cycles after grade_it.

Test Plan:
- Solve first guess: responder with master 1111, reset, start -> grade_it pulse with guess=12'h249; fb znarly=4 -> solved=1, guess_count=1, busy=0.
- Pruning: master 2222; guess 1111 returns 0/0 -> mask=6'b000001. The next issued guess is 12'h492 (2,2,2,2), not any pattern containing shape 1. Then solved, guess_count=2.
- Timeout: start with a responder that never asserts fb_valid -> timeout_err=1 exactly TIMEOUT_CYCLES cycles after grade_it; no further grade_it.
- Game over:
  - game_over asserted in GAP after the 3rd feedback -> failed=1, guess_count=3.
  - fb_valid with znarly=4 in the same cycle as game_over -> solved=1 (priority check).
- Abort and reset mid-WAIT:
  - abort -> IDLE next cycle, busy=0; a late fb_valid is ignored; a new start issues guess 12'h249 with guess_count=1.
  - reset mid-WAIT -> all outputs at reset values asynchronously.
- Exhaustion: responder always returns 2/0 -> 1296 guesses 1111..6666 in odometer order, guess_count saturates at 255, then failed=1.

Source files
------------

// File: rtl/mastermind_auto_guesser.sv
// Automatic Mastermind codebreaker: walks an odometer over shapes 1..6, skips candidates that
// contain shapes ruled out by 0/0 feedback, and drives the game core's grade/feedback handshake.
module mastermind_auto_guesser #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  znarly,
    input  logic [3:0]  zood,
    input  logic        fb_valid,
    input  logic        game_over,
    output logic [11:0] guess,
    output logic        grade_it,
    output logic        busy,
    output logic        solved,
    output logic        failed,
    output logic        timeout_err,
    output logic [7:0]  guess_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [11:0]   CAND_FIRST = 12'h249;
    localparam logic [11:0]   CAND_LAST  = 12'hDB6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE_OK,
        S_DONE_FAIL,
        S_DONE_TO
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [11:0]     cand;
    logic [5:0]      mask;
    logic [TW-1:0]   wait_timer;
    logic [GW-1:0]   gap_timer;
    logic            new_solve;
    logic            ld_issue;
    logic            inc_cand;
    logic            merge_mask;
    logic            admissible;
    logic [4:0]      fb_sum;

    // Slot0 is the least significant digit; each digit runs 1..6 and carries 6->1.
    function automatic logic [11:0] odo_inc(input logic [11:0] c);
        logic [11:0] r;
        logic        carry;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[3*i +: 3] == 3'd6) begin
                    r[3*i +: 3] = 3'd1;
                end else begin
                    r[3*i +: 3] = r[3*i +: 3] + 3'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // One bit per shape present in the pattern: bit k-1 for shape k.
    function automatic logic [5:0] shape_bits(input logic [11:0] g);
        logic [5:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 1; k <= 6; k++) begin
                if (g[3*i +: 3] == k[2:0]) b[k-1] = 1'b1;
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign admissible = ((shape_bits(cand) & mask) == 6'b0);
    assign fb_sum     = {1'b0, znarly} + {1'b0, zood};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt        = state;
        new_solve  = 1'b0;
        ld_issue   = 1'b0;
        inc_cand   = 1'b0;
        merge_mask = 1'b0;
        case (state)
            S_IDLE, S_DONE_OK, S_DONE_FAIL, S_DONE_TO: begin
                if (start) begin
                    new_solve = 1'b1;
                    nxt       = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (admissible) begin
                    ld_issue = 1'b1;
                    nxt      = S_ISSUE;
                end else if (cand != CAND_LAST) begin
                    inc_cand = 1'b1;
                end else begin
                    nxt = S_DONE_FAIL;
                end
            end
            S_ISSUE: nxt = S_WAIT;
            S_WAIT: begin
                if (fb_valid && znarly == 4'd4) begin
                    nxt = S_DONE_OK;
                end else if (fb_valid) begin
                    merge_mask = (fb_sum == 5'd0);
                    if (game_over || cand == CAND_LAST) begin
                        nxt = S_DONE_FAIL;
                    end else begin
                        inc_cand = 1'b1;
                        nxt      = S_GAP;
                    end
                end else if (game_over) begin
                    nxt = S_DONE_FAIL;
                end else if (wait_timer == WAIT_LAST) begin
                    nxt = S_DONE_TO;
                end
            end
            S_GAP: begin
                if (game_over)                   nxt = S_DONE_FAIL;
                else if (gap_timer == GAP_LAST)  nxt = S_SEARCH;
            end
            default: nxt = S_IDLE;
        endcase
        // abort wins over every transition and suppresses all datapath updates
        if (abort) begin
            nxt        = S_IDLE;
            new_solve  = 1'b0;
            ld_issue   = 1'b0;
            inc_cand   = 1'b0;
            merge_mask = 1'b0;
        end
    end

    always_comb begin
        grade_it    = (state == S_ISSUE);
        busy        = (state == S_SEARCH) || (state == S_ISSUE) ||
                      (state == S_WAIT)   || (state == S_GAP);
        solved      = (state == S_DONE_OK);
        failed      = (state == S_DONE_FAIL);
        timeout_err = (state == S_DONE_TO);
    end

    // Guess is loaded on the edge into ISSUE so it is already valid while grade_it is high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cand        <= CAND_FIRST;
            guess       <= CAND_FIRST;
            mask        <= '0;
            guess_count <= '0;
        end else if (new_solve) begin
            cand        <= CAND_FIRST;
            mask        <= '0;
            guess_count <= '0;
        end else begin
            if (inc_cand)   cand <= odo_inc(cand);
            if (merge_mask) mask <= mask | shape_bits(guess);
            if (ld_issue) begin
                guess       <= cand;
                guess_count <= sat_inc8(guess_count);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wait_timer <= '0;
            gap_timer  <= '0;
        end else begin
            if (state == S_ISSUE)     wait_timer <= '0;
            else if (state == S_WAIT) wait_timer <= wait_timer + TW'(1);
            if (state == S_GAP)       gap_timer  <= gap_timer + GW'(1);
            else                      gap_timer  <= '0;
        end
    end

endmodule
